// File: rtl/mod_const_pkg.sv
// mod_const_pkg: shared state encoding, default sizing and ID-width helper for the constant-divisor scheduler
package mod_const_pkg;
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
    localparam int DEF_WIDTH = 32;
    localparam longint unsigned DEF_DIVISOR = 1234101;
    function automatic int calc_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mod_const_iter_core.sv
// mod_const_iter_core: radix-2 restoring divider by a constant, one quotient bit per clock
module mod_const_iter_core #(
    parameter int WIDTH = 32,
    parameter longint unsigned DIVISOR = 1234101
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] DIV = (WIDTH + 1)'(DIVISOR);
    logic             run;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   acc_nxt;
    logic             fits;
    assign shifted = (acc << 1) | (WIDTH + 1)'(dvd[WIDTH-1]);
    assign fits    = shifted >= DIV;
    assign acc_nxt = fits ? shifted - DIV : shifted;
    assign done    = run && cnt == CW'(WIDTH - 1);
    // quo/rem present the values the final iteration is about to commit
    assign quo     = (q << 1) | WIDTH'(fits);
    assign rem     = acc_nxt[WIDTH-1:0];
    // one restoring step per edge while running; start reloads the operand
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= '0;
            acc <= '0;
            dvd <= '0;
            q   <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
            acc <= '0;
            dvd <= dividend;
            q   <= '0;
        end else if (run) begin
            run <= !done;
            cnt <= cnt + 1'b1;
            acc <= acc_nxt;
            dvd <= dvd << 1;
            q   <= quo;
        end
    end
endmodule

// File: rtl/mod_const_scheduler.sv
// mod_const_scheduler: round-robin sharing of one divide-by-constant engine; optional MOD_EARLY_OUT_EN bypasses small dividends
module mod_const_scheduler
    import mod_const_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WIDTH = DEF_WIDTH,
    parameter longint unsigned DIVISOR = DEF_DIVISOR,
    parameter int IDW = calc_idw(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_quo,
    output logic [WIDTH-1:0]      rsp_rem,
    output logic                  busy
);
`ifdef MOD_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam logic [NREQ-1:0] ONE = NREQ'(1);
    if (DIVISOR == 0 || (WIDTH < 64 && (DIVISOR >> WIDTH) != 0) || NREQ < 2 || NREQ > 8) begin : g_bad_cfg
        $error("mod_const_scheduler: DIVISOR must be nonzero and below 2^WIDTH, NREQ in 2..8");
    end
    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr, gnt;
    logic             gnt_any, accept, early, start, skip, done;
    logic [WIDTH-1:0] gnt_data, core_quo, core_rem;
    // first valid requester at or after rr_ptr; lower offsets overwrite higher ones
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                gnt_any = 1'b1;
                gnt     = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end
    assign gnt_data  = req_data[int'(gnt)*WIDTH +: WIDTH];
    assign accept    = state == IDLE && gnt_any;
    assign early     = EARLY && accept && gnt_data < WIDTH'(DIVISOR);
    assign start     = accept && !early;
    assign req_ready = accept ? ONE << gnt : '0;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;
    mod_const_iter_core #(.WIDTH(WIDTH), .DIVISOR(DIVISOR)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (gnt_data),
        .done     (done),
        .quo      (core_quo),
        .rem      (core_rem)
    );
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // next state: a bypassed operation spends a single cycle in CALC
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (done || skip) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // arbiter pointer and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            skip    <= 1'b0;
            rsp_id  <= '0;
            rsp_quo <= '0;
            rsp_rem <= '0;
        end else if (accept) begin
            rr_ptr <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
            skip   <= early;
            rsp_id <= gnt;
            if (early) begin
                rsp_quo <= '0;
                rsp_rem <= gnt_data;
            end
        end else if (state == CALC && done) begin
            rsp_quo <= core_quo;
            rsp_rem <= core_rem;
        end
    end
endmodule

// File: tb/tb_mod_const_scheduler.sv
// tb_mod_const_scheduler: randomized and directed checks against an arithmetic reference model
module tb_mod_const_scheduler;
    localparam int NREQ = 4;
    localparam int WIDTH = 32;
    localparam int IDW = 2;
    localparam longint D = 1234101;
`ifdef MOD_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int SMALL_LAT = EARLY ? 1 : WIDTH;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  rsp_ready = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_quo;
    logic [WIDTH-1:0]      rsp_rem;
    logic                  busy;

    int errors = 0;
    int checks = 0;
    // model: 0 idle, 1 computing (m_left edges to go), 2 holding a response
    int m_phase = 0;
    int m_left = 0;
    int m_rr = 0;
    int m_id = 0;
    logic [WIDTH-1:0] m_a = '0;
    bit auto_drop = 1'b1;
    bit acc = 1'b0;
    int acc_g = 0;
    int grants[$];

    always #5 clk = ~clk;

    mod_const_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_quo   (rsp_quo),
        .rsp_rem   (rsp_rem),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int grant();
        for (int k = 0; k < NREQ; k++)
            if (req_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        return -1;
    endfunction

    task automatic compare();
        int g;
        logic [NREQ-1:0] er;
        g = (m_phase == 0) ? grant() : -1;
        er = (g >= 0) ? NREQ'(1) << g : '0;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == 2));
        chk("busy", 64'(busy), 64'(m_phase != 0));
        if (m_phase == 2) begin
            chk("rsp_id", 64'(rsp_id), 64'(m_id));
            chk("rsp_quo", 64'(rsp_quo), 64'(longint'(m_a) / D));
            chk("rsp_rem", 64'(rsp_rem), 64'(longint'(m_a) % D));
        end
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants.push_back(i);
    endtask

    task automatic model_edge();
        int g;
        acc = 1'b0;
        if (m_phase == 0) begin
            g = grant();
            if (g >= 0) begin
                acc = 1'b1;
                acc_g = g;
                m_id = g;
                m_a = req_data[g*WIDTH +: WIDTH];
                m_rr = (g + 1) % NREQ;
                m_left = (EARLY && longint'(m_a) < D) ? 1 : WIDTH;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_left--;
            if (m_left == 0) m_phase = 2;
        end else if (rsp_ready) begin
            m_phase = 0;
        end
    endtask

    // called at a negedge with inputs already set; returns at the next negedge
    task automatic step();
        #1 compare();
        @(posedge clk);
        if (rst_n) model_edge();
        else acc = 1'b0;
        @(negedge clk);
        if (auto_drop && acc) req_valid[acc_g] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        m_phase = 0;
        m_rr = 0;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_rsp_quo", 64'(rsp_quo), 64'd0);
        chk("reset_rsp_rem", 64'(rsp_rem), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        rsp_ready = 1'b1;
        while ((req_valid != '0 || m_phase != 0) && n < 500) begin
            step();
            n++;
        end
        chk("drain_in_time", 64'(n < 500), 64'd1);
    endtask

    task automatic run_one(input int id, input logic [WIDTH-1:0] a, input longint q, input longint r, input int lat_exp);
        int lat = 0;
        rsp_ready = 1'b0;
        req_valid[id] = 1'b1;
        req_data[id*WIDTH +: WIDTH] = a;
        step();
        while (!rsp_valid && lat < 200) begin
            step();
            lat++;
        end
        chk("latency", 64'(lat), 64'(lat_exp));
        chk("lit_id", 64'(rsp_id), 64'(id));
        chk("lit_quo", 64'(rsp_quo), 64'(q));
        chk("lit_rem", 64'(rsp_rem), 64'(r));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    function automatic logic [WIDTH-1:0] rand_data();
        case ($urandom % 4)
            0:       return '0;
            1:       return WIDTH'($urandom_range(0, 32'(D - 1)));
            2:       return WIDTH'($urandom);
            default: return 32'hFFFF_FFFF - WIDTH'($urandom % 16);
        endcase
    endfunction

    initial begin
        int lat;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        #2;
        @(negedge clk);
        do_reset();
        run_one(0, 32'hFFFF_FFFF, 3480, 295815, WIDTH);
        run_one(1, 32'd1234101, 1, 0, WIDTH);
        run_one(2, 32'd2468203, 2, 1, WIDTH);
        run_one(3, 32'd0, 0, 0, SMALL_LAT);
        run_one(0, 32'd1000, 0, 1000, SMALL_LAT);
        run_one(1, 32'(D - 1), 0, D - 1, SMALL_LAT);

        // response held back for 10 cycles while other requesters wait
        req_valid[1] = 1'b1;
        req_data[1*WIDTH +: WIDTH] = 32'hDEAD_BEEF;
        step();
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            step();
            lat++;
        end
        req_valid[0] = 1'b1;
        req_data[0*WIDTH +: WIDTH] = 32'h1234_5678;
        req_valid[3] = 1'b1;
        req_data[3*WIDTH +: WIDTH] = 32'h0000_0042;
        repeat (10) step();
        chk("stall_ready", 64'(req_ready), 64'd0);
        chk("stall_quo", 64'(rsp_quo), 64'(32'hDEAD_BEEF / 32'd1234101));
        drain();

        // reset in the middle of an operation
        rsp_ready = 1'b0;
        req_valid[2] = 1'b1;
        req_data[2*WIDTH +: WIDTH] = 32'h8000_0001;
        repeat (16) step();
        do_reset();
        repeat (5) step();
        chk("post_reset_valid", 64'(rsp_valid), 64'd0);
        req_valid[0] = 1'b1;
        req_data[0*WIDTH +: WIDTH] = 32'h0BAD_F00D;
        req_valid[1] = 1'b1;
        req_data[1*WIDTH +: WIDTH] = 32'h7777_7777;
        #1 chk("rr_after_reset", 64'(req_ready), 64'd1);
        drain();

        // all requesters hold valid: strict rotation from pointer 0
        do_reset();
        auto_drop = 1'b0;
        grants.delete();
        for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = rand_data();
        req_valid = '1;
        rsp_ready = 1'b1;
        lat = 0;
        while (grants.size() < 5 && lat < 400) begin
            step();
            lat++;
        end
        req_valid = '0;
        auto_drop = 1'b1;
        chk("grant_count", 64'(grants.size() >= 5), 64'd1);
        for (int i = 0; i < 5; i++)
            chk("grant_order", 64'((i < grants.size()) ? grants[i] : -1), 64'(exp_order[i]));
        drain();

        // random traffic with random back-pressure
        repeat (3000) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom % 4 == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*WIDTH +: WIDTH] = rand_data();
                end
            end
            rsp_ready = ($urandom % 3) != 0;
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
